truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequencer that drives the three-input combinational function Y = (~C & D) | (B & D) through all eight input combinations and samples Y for each. It assembles the sampled outputs into an 8-bit truth table and compares it against a golden table. It reports pass/fail and the first failing vector. It sits between a start/abort control source (board switch debouncer or testbench) and the gate-level function block, which it owns exclusively while busy.

## Interface
- SETTLE_CYCLES, 1: cycles each vector is held before Y is sampled; legal range 1..15.
- EXPECTED, 8'hA2: golden truth table, bit i = Y for {B,C,D} = i.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level, sampled each edge; begins a sweep when idle
- abort  in  1  level; terminates a sweep in progress
- dut_b, dut_c, dut_d  out  1 each  registered drive to the function's B, C, D inputs
- dut_y  in  1  function output
- busy  out  1  high while a sweep is in progress
- done  out  1  single-cycle pulse at sweep completion
- pass  out  1  sweep result, valid from done; held until next accepted start
- truth_table  out  8  captured Y values, bit i = vector i
- fail_valid  out  1  at least one mismatch seen in the current/last sweep
- first_fail  out  3  index of the lowest mismatching vector; 0 when fail_valid=0

## Operation
- States: IDLE, SETTLE, SAMPLE, FINISH.
- **IDLE:**
  - dut_b/c/d = 0, busy = 0.
  - start=1 and abort=0: clear truth_table, fail_valid, first_fail, pass; idx←0, cnt←0; go SETTLE.
- **SETTLE:**
  - {dut_b,dut_c,dut_d} = idx.
  - cnt increments each cycle; after SETTLE_CYCLES cycles in SETTLE, go SAMPLE.
- **SAMPLE:**
  - truth_table[idx]←dut_y.
  - If dut_y ≠ EXPECTED[idx] and fail_valid=0: fail_valid←1, first_fail←idx.
  - idx=7 → FINISH; else idx←idx+1, cnt←0, go SETTLE.
- **FINISH:**
  - done=1 for exactly this cycle; pass←(fail_valid=0 including this sweep's last sample), i.e. captured table == EXPECTED.
  - Return to IDLE.
- **Input handling:**
  - start while busy: ignored.
  - start held high continuously: a new sweep begins one cycle after FINISH.
  - abort=1 in SETTLE or SAMPLE: next state IDLE. No done pulse; pass=0; truth_table and fail fields keep their partial contents.
  - abort=1 in FINISH: ignored; completion stands.
  - start and abort both high in IDLE: abort wins, stay IDLE.
- idx is 3 bits and never wraps inside a sweep; FINISH is the only exit after idx=7.
- **Reset** (any time, including mid-sweep): state IDLE; all outputs 0 (dut_b/c/d, busy, done, pass, truth_table, fail_valid, first_fail); idx and cnt 0.

## Timing
- start sampled high in IDLE at edge k → busy=1 and vector 0 driven from edge k+1.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in SETTLE, 1 in SAMPLE.
- dut_y is sampled in the last cycle the vector is driven. The function is purely combinational, so SETTLE_CYCLES=1 suffices in simulation.
- done is high in the cycle starting at edge k+1+8·(SETTLE_CYCLES+1). With the default that is edge k+17.
- busy drops at the same edge done rises: busy=0 in FINISH.
- pass, truth_table and fail fields are stable from the done cycle until the next accepted start.

## Structure
- Shared package ddco_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, FINISH; 2-bit);
  - SWEEP_VECTORS = 8;
  - default golden table constant 8'hA2.
- Sub-module: settle_timer, a 4-bit down-counter with load/expire and SETTLE_CYCLES as a parameter. The FSM and capture/compare logic stay in the top.
- The function block is instantiated beside this one at the level above, not inside it.

## Test plan
- Reset then start pulse, correct function, SETTLE_CYCLES=1 → vectors 0..7 driven in order, done at edge k+17, truth_table=8'hA2, pass=1, fail_valid=0.
- Function replaced by Y stuck-at-1 → truth_table=8'hFF, pass=0, fail_valid=1, first_fail=0.
- Function with C inverter removed (Y = C&D | B&D) → truth_table=8'hA8, first_fail=1, pass=0.
- abort asserted in the SETTLE cycle of vector 4 → IDLE next cycle, no done, busy=0, dut inputs 0, truth_table bits 3..0 = 4'h2.
- start held high for 40 cycles, SETTLE_CYCLES=3 → done at k+33. Second sweep begins the cycle after FINISH; the start pulse issued mid-sweep is ignored.
- rst_n pulled low at vector 6 → all outputs 0 immediately (asynchronously). After release, stays IDLE until start.

Source files
------------

// File: rtl/ddco_pkg.sv
// Shared types and constants for the truth-table sweeper.
package ddco_pkg;

  // Sweeper sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Number of input combinations of the three-input function {B,C,D}.
  localparam int unsigned SWEEP_VECTORS = 8;

  // Golden truth table of Y = (~C & D) | (B & D); bit i = Y for {B,C,D} = i.
  localparam logic [7:0] GOLDEN_TABLE = 8'hA2;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle timer: 4-bit down-counter that times how long a vector is held
// before its output is sampled. It reloads while load_i is high and
// counts down while en_i is high; expire_o flags the final hold cycle.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES);

  logic [3:0] count_q;

  // Reload with the hold length, otherwise count down towards zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else if (load_i) begin
      count_q <= LOAD_VAL;
    end else if (en_i && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  // A count of one while enabled is the last cycle of the hold window.
  assign expire_o = en_i && (count_q == 4'd1);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives the external three-input function through
// all eight {B,C,D} combinations, captures Y for each, compares the result
// against a golden table and reports pass/fail plus the first failing
// vector.
//
// Control handshake: start and abort are plain levels sampled on every
// rising edge. start is registered once (qualified by abort) before the
// idle state acts on it, so a start seen at edge k makes busy rise and
// vector 0 appear from edge k+1. abort acts directly: in SETTLE/SAMPLE it
// returns to IDLE at the next edge; in IDLE it blocks a start.
module truth_table_sweeper
  import ddco_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  EXPECTED      = GOLDEN_TABLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       dut_b,
  output logic       dut_c,
  output logic       dut_d,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic       fail_valid,
  output logic [2:0] first_fail,
  output state_t     dbg_state
);

  localparam logic [2:0] LAST_IDX = 3'(SWEEP_VECTORS - 1);

  state_t     state_q;
  logic [2:0] idx_q;
  logic [2:0] drive_q;
  logic       start_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] table_q;
  logic       fail_valid_q;
  logic [2:0] first_fail_q;

  logic       expire;
  logic       mismatch;
  logic       last_vec;

  // The timer is held loaded outside SETTLE, so every SETTLE entry starts
  // a fresh hold window of SETTLE_CYCLES cycles.
  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (state_q != SETTLE),
    .en_i     (state_q == SETTLE),
    .expire_o (expire)
  );

  assign mismatch = (dut_y != EXPECTED[idx_q]);
  assign last_vec = (idx_q == LAST_IDX);

  // Sweep sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      drive_q      <= 3'd0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      table_q      <= 8'd0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 3'd0;
    end else begin
      start_q <= start & ~abort;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_q && !abort) begin
            table_q      <= 8'd0;
            fail_valid_q <= 1'b0;
            first_fail_q <= 3'd0;
            pass_q       <= 1'b0;
            idx_q        <= 3'd0;
            drive_q      <= 3'd0;
            busy_q       <= 1'b1;
            state_q      <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            busy_q  <= 1'b0;
            drive_q <= 3'd0;
            pass_q  <= 1'b0;
            state_q <= IDLE;
          end else if (expire) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            busy_q  <= 1'b0;
            drive_q <= 3'd0;
            pass_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            table_q[idx_q] <= dut_y;
            if (mismatch && !fail_valid_q) begin
              fail_valid_q <= 1'b1;
              first_fail_q <= idx_q;
            end
            if (last_vec) begin
              // The final sample is folded into pass here, since
              // fail_valid_q only reflects it from the next cycle.
              pass_q  <= !(fail_valid_q || mismatch);
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              drive_q <= 3'd0;
              state_q <= FINISH;
            end else begin
              idx_q   <= idx_q + 3'd1;
              drive_q <= idx_q + 3'd1;
              state_q <= SETTLE;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign {dut_b, dut_c, dut_d} = drive_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign truth_table = table_q;
  assign fail_valid  = fail_valid_q;
  assign first_fail  = first_fail_q;
  assign dbg_state   = state_q;

endmodule
